// File: rtl/if_fetch_pkg.sv
// Shared bus widths, constants and FSM encoding for the instruction-fetch stage.
package if_fetch_pkg;

  localparam int ADDR_W  = 32;
  localparam int INST_W  = 32;
  localparam int STALL_W = 6;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  localparam logic [INST_W-1:0] ZERO_WORD    = '0;
  localparam logic [ADDR_W-1:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DROP
  } fetch_state_e;

endpackage

// File: rtl/if_icache.sv
// Direct-mapped instruction cache: tag/valid/data arrays with a combinational
// lookup port and a single synchronous fill port.
module if_icache
  import if_fetch_pkg::*;
#(
  parameter int ENTRIES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] lookup_addr_i,
  output logic              hit_o,
  output logic [INST_W-1:0] lookup_data_o,
  input  logic              fill_en_i,
  input  logic [ADDR_W-1:0] fill_addr_i,
  input  logic [INST_W-1:0] fill_data_i
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q  [ENTRIES];
  logic [INST_W-1:0]  data_q [ENTRIES];

  logic [IDX_W-1:0] lk_idx, fill_idx;
  logic [TAG_W-1:0] lk_tag, fill_tag;
  logic             unused_addr_bits;

  assign lk_idx   = lookup_addr_i[IDX_W+1:2];
  assign lk_tag   = lookup_addr_i[ADDR_W-1:IDX_W+2];
  assign fill_idx = fill_addr_i[IDX_W+1:2];
  assign fill_tag = fill_addr_i[ADDR_W-1:IDX_W+2];
  assign unused_addr_bits = ^{lookup_addr_i[1:0], fill_addr_i[1:0]};

  assign hit_o         = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign lookup_data_o = data_q[lk_idx];

  // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (fill_en_i) begin
      valid_q[fill_idx] <= 1'b1;
    end
  end

  // NOTE: tag/data arrays are deliberately not reset; the valid bits alone gate their use.
  always_ff @(posedge clk) begin
    if (fill_en_i) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= fill_data_i;
    end
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC register, miss-handling FSM and the instruction
// cache instance. Hits are presented combinationally in the same cycle.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter int                ICACHE_ENTRIES = 16,
  parameter logic [ADDR_W-1:0] RESET_PC       = RESET_PC_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  input  logic               jump_enable,
  input  logic [ADDR_W-1:0]  jump_addr,
  input  logic [STALL_W-1:0] stall_ctrler,
  input  logic               mem_done,
  input  logic [INST_W-1:0]  mem_inst,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [INST_W-1:0]  if_inst,
  output logic               if_stall_req,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              hit;
  logic [INST_W-1:0] cache_word;
  logic              fill_en;
  logic              unused_stall_bits;

  assign unused_stall_bits = ^stall_ctrler[STALL_W-1:1];

  // A fill lands whenever a response arrives while a request is open, including from DROP.
  assign fill_en = rdy && mem_done && (state_q != ST_IDLE);

  if_icache #(
    .ENTRIES(ICACHE_ENTRIES)
  ) u_icache (
    .clk          (clk),
    .rst          (rst),
    .lookup_addr_i(pc_q),
    .hit_o        (hit),
    .lookup_data_o(cache_word),
    .fill_en_i    (fill_en),
    .fill_addr_i  (mem_addr_q),
    .fill_data_i  (mem_inst)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else if (rdy) begin
      state_q <= state_d;
    end
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (!hit && !jump_enable) state_d = ST_FETCH;
      ST_FETCH: begin
        if (mem_done)         state_d = ST_IDLE;
        else if (jump_enable) state_d = ST_DROP;
      end
      ST_DROP:  if (mem_done) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_req      = (state_q != ST_IDLE) ? ENABLE : DISABLE;
    if_stall_req = DISABLE;
    if_inst      = ZERO_WORD;
    if (rst) begin
      if_stall_req = (state_q != ST_IDLE) || !hit;
      if (state_q == ST_IDLE && hit) if_inst = cache_word;
    end
  end

  always_comb begin
    pc_d       = pc_q;
    mem_addr_d = mem_addr_q;
    if (jump_enable)                              pc_d = jump_addr;
    else if (!stall_ctrler[0] && !if_stall_req)   pc_d = pc_q + 32'd4;
    if (state_q == ST_IDLE && state_d == ST_FETCH) mem_addr_d = pc_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q       <= RESET_PC;
      mem_addr_q <= '0;
    end else if (rdy) begin
      pc_q       <= pc_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  assign if_pc    = pc_q;
  assign mem_addr = mem_addr_q;

endmodule
